// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill path: word-addressed backing store
// answering one read/write request at a time after a fixed latency.
module cache_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int LATENCY    = 4
) (
    input  logic                  clk_i,
    input  logic                  areset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                  we;
        logic                  err;
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    state_t                state;
    req_t                  req_q;
    req_t                  req_in;
    req_t                  cur;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  accept;
    logic                  enter_resp;

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign accept      = req_ready_o && req_valid_i;

    always_comb begin
        req_in      = '0;
        req_in.we   = req_we_i;
        req_in.err  = |req_addr_i[ADDR_WIDTH-1:IDX_W];
        req_in.idx  = req_addr_i[IDX_W-1:0];
        req_in.data = req_data_i;
    end

    // With LATENCY == 1 the commit happens on the accept edge, so it must use
    // the live request rather than the latched copy.
    assign cur        = (state == IDLE) ? req_in : req_q;
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state == WAIT) && (cnt == CNT_W'(1)));

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state      <= IDLE;
            req_q      <= '0;
            cnt        <= '0;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (enter_resp) begin
                rsp_err_o  <= cur.err;
                rsp_data_o <= (cur.we || cur.err) ? '0 : mem[cur.idx];
                if (cur.we && !cur.err) mem[cur.idx] <= cur.data;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q <= req_in;
                        cnt   <= CNT_W'(LATENCY - 1);
                        state <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state      <= IDLE;
                        rsp_data_o <= '0;
                        rsp_err_o  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
